// File: rtl/exec_issue.sv
// exec_issue: decode/issue stage feeding the execute-stage arith/shift ALU.
// Accepts one instruction plus operands per instr_valid/instr_ready handshake,
// issues registered ALU operands/controls, and drives data-memory strobes.
// Loads are sequenced through LOAD_REQ/LOAD_DATA(/LOAD_HOLD) and reach the ALU
// as an ADD with aluin1 = 0.
// Ports:
//   CLOCK, RESET          rising-edge clock, synchronous active-high reset
//   enable_ex             execute stage may advance (0 = stall)
//   instr_valid/ready     instruction handshake (ready is combinational)
//   instr, src1, src2     instruction word and register operands
//   mem_*                 data-memory read/write interface
//   aluin1/2, operation_out, opselect_out, enable_arith, enable_shift,
//   shift_number, out_valid   registered ALU-side outputs
module exec_issue #(
  parameter int unsigned REGISTER_WIDTH  = 32,
  parameter int unsigned IMMEDIATE_WIDTH = 16
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      enable_ex,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [31:0]               instr,
  input  logic [REGISTER_WIDTH-1:0] src1,
  input  logic [REGISTER_WIDTH-1:0] src2,
  input  logic [REGISTER_WIDTH-1:0] mem_data_read_in,
  output logic                      mem_rd_req,
  output logic [REGISTER_WIDTH-1:0] mem_addr,
  output logic [REGISTER_WIDTH-1:0] mem_data_write_out,
  output logic                      mem_data_wr_en,
  output logic [REGISTER_WIDTH-1:0] aluin1,
  output logic [REGISTER_WIDTH-1:0] aluin2,
  output logic [2:0]                operation_out,
  output logic [2:0]                opselect_out,
  output logic                      enable_arith,
  output logic                      enable_shift,
  output logic [4:0]                shift_number,
  output logic                      out_valid
);

  localparam int unsigned RW = REGISTER_WIDTH;
  localparam int unsigned IW = IMMEDIATE_WIDTH;

  localparam logic [2:0] SEL_SHIFT = 3'b000;
  localparam logic [2:0] SEL_ARITH = 3'b001;
  localparam logic [2:0] SEL_STORE = 3'b100;
  localparam logic [2:0] SEL_LOAD  = 3'b101;

  typedef enum logic [1:0] {IDLE, LOAD_REQ, LOAD_DATA, LOAD_HOLD} state_t;

  state_t          r_state;
  logic [2:0]      r_ld_op;
  logic [RW-1:0]   r_hold;

  logic [2:0]      w_opsel;
  logic [2:0]      w_op;
  logic            w_immp;
  logic [4:0]      w_shamt;
  logic [IW-1:0]   w_imm;
  logic [RW-1:0]   w_sext;
  logic [RW-1:0]   w_addr;
  logic            w_accept;
  logic [RW-1:0]   w_fmt;
  logic [RW-1:0]   w_ld_val;
  logic            w_unused;

  // Instruction field decode
  assign w_opsel  = instr[31:29];
  assign w_op     = instr[28:26];
  assign w_immp   = instr[25];
  assign w_shamt  = instr[24:20];
  assign w_imm    = instr[IW-1:0];
  assign w_sext   = {{(RW-IW){w_imm[IW-1]}}, w_imm};
  assign w_addr   = src1 + w_sext;
  assign w_unused = ^instr[19:16];

  assign instr_ready = (r_state == IDLE) && enable_ex;
  assign w_accept    = instr_valid && instr_ready;

  // Load data formatting by the latched load operation
  always_comb begin
    w_fmt = mem_data_read_in;
    case (r_ld_op)
      3'b000:  w_fmt = {{(RW-8){mem_data_read_in[7]}}, mem_data_read_in[7:0]};
      3'b100:  w_fmt = {{(RW-8){1'b0}}, mem_data_read_in[7:0]};
      3'b001:  w_fmt = {{(RW-16){mem_data_read_in[15]}}, mem_data_read_in[15:0]};
      3'b101:  w_fmt = {{(RW-16){1'b0}}, mem_data_read_in[15:0]};
      default: w_fmt = mem_data_read_in;
    endcase
  end

  // Stalled loads issue from the hold register, fresh ones straight from memory
  assign w_ld_val = (r_state == LOAD_HOLD) ? r_hold : w_fmt;

  // Issue FSM and registered outputs
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state            <= IDLE;
      r_ld_op            <= '0;
      r_hold             <= '0;
      mem_rd_req         <= 1'b0;
      mem_addr           <= '0;
      mem_data_write_out <= '0;
      mem_data_wr_en     <= 1'b0;
      aluin1             <= '0;
      aluin2             <= '0;
      operation_out      <= '0;
      opselect_out       <= '0;
      enable_arith       <= 1'b0;
      enable_shift       <= 1'b0;
      shift_number       <= '0;
      out_valid          <= 1'b0;
    end else begin
      // Pulses drop when the execute stage advances; an issue below re-asserts
      if (enable_ex) begin
        enable_arith   <= 1'b0;
        enable_shift   <= 1'b0;
        out_valid      <= 1'b0;
        mem_data_wr_en <= 1'b0;
      end
      mem_rd_req <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (w_opsel)
              SEL_ARITH: begin
                aluin1        <= src1;
                aluin2        <= w_immp ? w_sext : src2;
                operation_out <= w_op;
                opselect_out  <= w_opsel;
                enable_arith  <= 1'b1;
                out_valid     <= 1'b1;
              end
              SEL_SHIFT: begin
                aluin1        <= src1;
                shift_number  <= w_immp ? w_shamt : src2[4:0];
                operation_out <= w_op;
                opselect_out  <= w_opsel;
                enable_shift  <= 1'b1;
                out_valid     <= 1'b1;
              end
              SEL_STORE: begin
                mem_addr           <= w_addr;
                mem_data_write_out <= src2;
                mem_data_wr_en     <= 1'b1;
              end
              SEL_LOAD: begin
                r_ld_op    <= w_op;
                mem_addr   <= w_addr;
                mem_rd_req <= 1'b1;
                r_state    <= LOAD_REQ;
              end
              default: ;
            endcase
          end
        end
        LOAD_REQ: r_state <= LOAD_DATA;
        LOAD_DATA, LOAD_HOLD: begin
          if (enable_ex) begin
            aluin1        <= '0;
            aluin2        <= w_ld_val;
            operation_out <= 3'b000;
            opselect_out  <= SEL_LOAD;
            enable_arith  <= 1'b1;
            out_valid     <= 1'b1;
            r_state       <= IDLE;
          end else if (r_state == LOAD_DATA) begin
            r_hold  <= w_fmt;
            r_state <= LOAD_HOLD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_issue.sv
// Self-checking bench for exec_issue: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_exec_issue;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        enable_ex = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [31:0] mem_data_read_in = '0;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_write_out;
  logic        mem_data_wr_en;
  logic [31:0] aluin1;
  logic [31:0] aluin2;
  logic [2:0]  operation_out;
  logic [2:0]  opselect_out;
  logic        enable_arith;
  logic        enable_shift;
  logic [4:0]  shift_number;
  logic        out_valid;

  exec_issue dut (
    .CLOCK(CLOCK), .RESET(RESET), .enable_ex(enable_ex),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .src1(src1), .src2(src2), .mem_data_read_in(mem_data_read_in),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_data_write_out(mem_data_write_out), .mem_data_wr_en(mem_data_wr_en),
    .aluin1(aluin1), .aluin2(aluin2), .operation_out(operation_out),
    .opselect_out(opselect_out), .enable_arith(enable_arith),
    .enable_shift(enable_shift), .shift_number(shift_number), .out_valid(out_valid)
  );

  always #5 CLOCK = ~CLOCK;

  int errors = 0;
  int checks = 0;

  // Reference model: expected outputs plus load progress in edges since acceptance
  logic [31:0] e_a1, e_a2, e_addr, e_wd;
  logic [2:0]  e_op, e_sel;
  logic [4:0]  e_sh;
  logic        e_ea, e_es, e_ov, e_rd, e_we;
  int          m_age;
  logic        m_have;
  logic [2:0]  m_op;
  logic [31:0] m_val;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] sel, input logic [2:0] op,
                                     input logic immp, input logic [4:0] shamt,
                                     input logic [15:0] imm);
    return {sel, op, immp, shamt, 4'b0000, imm};
  endfunction

  function automatic logic [31:0] sx16(input logic [15:0] v);
    return 32'($signed(v));
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] op, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[7:0];
    h = d[15:0];
    if (op == 3'b000) return 32'($signed(b));
    if (op == 3'b100) return 32'(b);
    if (op == 3'b001) return 32'($signed(h));
    if (op == 3'b101) return 32'(h);
    return d;
  endfunction

  function automatic logic [143:0] dut_vec();
    return {aluin1, aluin2, operation_out, opselect_out, enable_arith, enable_shift,
            shift_number, out_valid, mem_rd_req, mem_addr, mem_data_write_out, mem_data_wr_en};
  endfunction

  function automatic logic [143:0] exp_vec();
    return {e_a1, e_a2, e_op, e_sel, e_ea, e_es, e_sh, e_ov, e_rd, e_addr, e_wd, e_we};
  endfunction

  task automatic model_reset();
    e_a1 = '0; e_a2 = '0; e_addr = '0; e_wd = '0; e_op = '0; e_sel = '0; e_sh = '0;
    e_ea = 0; e_es = 0; e_ov = 0; e_rd = 0; e_we = 0;
    m_age = 0; m_have = 0; m_op = '0; m_val = '0;
  endtask

  // One clock cycle: drive inputs, predict the edge, compare ready and all outputs
  task automatic cyc(input string tag, input logic en, input logic v,
                     input logic [31:0] ins, input logic [31:0] s1,
                     input logic [31:0] s2, input logic [31:0] md);
    logic rdy;
    logic [2:0] sel, op;
    enable_ex = en; instr_valid = v; instr = ins; src1 = s1; src2 = s2;
    mem_data_read_in = md;
    rdy = (m_age == 0) && en;
    sel = ins[31:29];
    op  = ins[28:26];
    #1;
    checks++;
    if (instr_ready !== rdy) begin
      errors++;
      $display("FAIL %s instr_ready got=%b exp=%b", tag, instr_ready, rdy);
    end
    if (RESET) begin
      model_reset();
    end else begin
      e_rd = 0;
      if (en) begin e_ea = 0; e_es = 0; e_ov = 0; e_we = 0; end
      if (m_age == 1) begin
        m_age = 2;
      end else if (m_age == 2) begin
        if (!m_have) begin m_val = load_fmt(m_op, md); m_have = 1; end
        if (en) begin
          e_a1 = '0; e_a2 = m_val; e_op = 3'b000; e_sel = 3'b101;
          e_ea = 1; e_es = 0; e_ov = 1;
          m_age = 0; m_have = 0;
        end
      end else if (v && rdy) begin
        if (sel == 3'b001) begin
          e_a1 = s1; e_a2 = ins[25] ? sx16(ins[15:0]) : s2;
          e_op = op; e_sel = sel; e_ea = 1; e_ov = 1;
        end else if (sel == 3'b000) begin
          e_a1 = s1; e_sh = ins[25] ? ins[24:20] : s2[4:0];
          e_op = op; e_sel = sel; e_es = 1; e_ov = 1;
        end else if (sel == 3'b100) begin
          e_addr = s1 + sx16(ins[15:0]); e_wd = s2; e_we = 1;
        end else if (sel == 3'b101) begin
          m_op = op; e_addr = s1 + sx16(ins[15:0]); e_rd = 1; m_age = 1;
        end
      end
    end
    @(posedge CLOCK);
    #1;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL %s outputs got=%h exp=%h", tag, dut_vec(), exp_vec());
    end
  endtask

  task automatic idle(input string tag, input logic en);
    cyc(tag, en, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    RESET = 1; enable_ex = 0; instr_valid = 0;
    tick(); tick();
    model_reset();
    checks++;
    if (dut_vec() !== 144'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
    RESET = 0;
    idle("reset_release", 1'b1);
  endtask

  task automatic test_reset_mid_load();
    cyc("rml_accept", 1, 1, mk(3'b101, 3'b011, 0, 0, 16'h0010), 32'h200, 0, 0);
    RESET = 1;
    cyc("rml_rst0", 1, 0, 0, 0, 0, 32'h55);
    cyc("rml_rst1", 1, 0, 0, 0, 0, 32'h55);
    RESET = 0;
    idle("rml_idle0", 1);
    idle("rml_idle1", 1);
    checks++;
    if (mem_rd_req !== 1'b0 || out_valid !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rml_quiet rd=%b ov=%b rdy=%b exp rd=0 ov=0 rdy=1",
               mem_rd_req, out_valid, instr_ready);
    end
  endtask

  task automatic test_arith_imm();
    cyc("arith_issue", 1, 1, mk(3'b001, 3'b000, 1, 0, 16'hFFFE), 32'd5, 32'h77, 0);
    checks++;
    if ({aluin1, aluin2, enable_arith, enable_shift, out_valid} !==
        {32'd5, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL arith_const got a1=%h a2=%h ea=%b es=%b ov=%b", aluin1, aluin2,
               enable_arith, enable_shift, out_valid);
    end
    idle("arith_drop", 1);
  endtask

  task automatic test_shift_reg();
    cyc("shift_issue", 1, 1, mk(3'b000, 3'b010, 0, 5'd17, 16'h0), 32'h80000000, 32'h23, 0);
    checks++;
    if ({aluin1, shift_number, enable_shift, enable_arith} !== {32'h80000000, 5'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL shift_const got a1=%h sh=%0d es=%b ea=%b exp 80000000 3 1 0",
               aluin1, shift_number, enable_shift, enable_arith);
    end
    idle("shift_drop", 1);
  endtask

  task automatic test_load_byte();
    cyc("lb_accept", 1, 1, mk(3'b101, 3'b000, 0, 0, 16'd4), 32'h100, 0, 0);
    checks++;
    if (mem_rd_req !== 1'b1 || mem_addr !== 32'h104) begin
      errors++;
      $display("FAIL lb_req got rd=%b addr=%h exp rd=1 addr=00000104", mem_rd_req, mem_addr);
    end
    cyc("lb_req", 1, 0, 0, 0, 0, 32'hBAD0BAD0);
    cyc("lb_data", 1, 0, 0, 0, 0, 32'h000000F0);
    checks++;
    if ({aluin1, aluin2, operation_out, enable_arith} !== {32'h0, 32'hFFFFFFF0, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL lb_issue got a1=%h a2=%h op=%b ea=%b", aluin1, aluin2,
               operation_out, enable_arith);
    end
    idle("lb_drop", 1);
  endtask

  task automatic test_load_stall();
    cyc("lhs_accept", 1, 1, mk(3'b101, 3'b101, 0, 0, 16'd4), 32'h100, 0, 0);
    cyc("lhs_req", 1, 0, 0, 0, 0, 32'h0);
    cyc("lhs_data", 0, 1, mk(3'b001, 0, 0, 0, 0), 0, 0, 32'h1234ABCD);
    cyc("lhs_hold1", 0, 1, mk(3'b001, 0, 0, 0, 0), 0, 0, 32'hFFFFFFFF);
    cyc("lhs_hold2", 0, 1, mk(3'b001, 0, 0, 0, 0), 0, 0, 32'h0);
    cyc("lhs_release", 1, 0, 0, 0, 0, 32'h0);
    checks++;
    if (aluin2 !== 32'h0000ABCD || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL lhs_issue got a2=%h ov=%b exp a2=0000ABCD ov=1", aluin2, out_valid);
    end
    idle("lhs_drop", 1);
  endtask

  task automatic test_store_nop();
    cyc("st_accept", 1, 1, mk(3'b100, 3'b000, 0, 0, 16'hFFFC), 32'd8, 32'hDEADBEEF, 0);
    checks++;
    if ({mem_addr, mem_data_write_out, mem_data_wr_en, enable_arith, enable_shift} !==
        {32'd4, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL st_const got addr=%h wd=%h we=%b ea=%b es=%b", mem_addr,
               mem_data_write_out, mem_data_wr_en, enable_arith, enable_shift);
    end
    cyc("nop_accept", 1, 1, mk(3'b110, 3'b011, 1, 5'd9, 16'h1234), 32'h9, 32'h9, 0);
    checks++;
    if ({out_valid, mem_data_wr_en, mem_rd_req, enable_arith, enable_shift} !== 5'b0) begin
      errors++;
      $display("FAIL nop_quiet got ov=%b we=%b rd=%b ea=%b es=%b exp all 0", out_valid,
               mem_data_wr_en, mem_rd_req, enable_arith, enable_shift);
    end
  endtask

  task automatic test_back_to_back();
    cyc("b2b_0", 1, 1, mk(3'b001, 3'b001, 0, 0, 0), 32'h11, 32'h22, 0);
    cyc("b2b_1", 1, 1, mk(3'b000, 3'b100, 1, 5'd31, 0), 32'h33, 32'h44, 0);
    cyc("b2b_2", 1, 1, mk(3'b001, 3'b111, 1, 0, 16'h7FFF), 32'h55, 32'h66, 0);
    cyc("b2b_stall", 0, 1, mk(3'b000, 3'b000, 0, 0, 0), 32'h1, 32'h2, 0);
    idle("b2b_drop", 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      cyc("random", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, ins,
          $urandom, $urandom, $urandom);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_mid_load();
    test_arith_imm();
    test_shift_reg();
    test_load_byte();
    test_load_stall();
    test_store_nop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
